mem_request_arbiter: RTL
========================

Name: mem_request_arbiter

Overview:
- Memory-side responder for the datapath's instruction-fetch and data-access requests (iREN, dREN, dWEN).
- Arbitrates both requesters onto a single RAM port and tracks RAM wait states.
- Returns ihit/dhit completion strobes and load data to the datapath and request unit.
- Sits between the datapath and the shared RAM model; stops fetch once the core halts.

Parameters:
- ADDR_W, 32, address width in bits.
- WORD_W, 32, data word width in bits.
- ERR_RETRY_MAX, 4, consecutive RAM ERROR responses tolerated per access before aborting it.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request; held until ihit
- iaddr  in  ADDR_W  fetch address
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit (dREN and dWEN never both 1)
- daddr  in  ADDR_W  data address
- dstore  in  WORD_W  store data
- halt  in  1  core halted; blocks new instruction grants
- ihit  out  1  instruction access complete this cycle
- dhit  out  1  data access complete this cycle
- iload  out  WORD_W  fetched word, valid when ihit
- dload  out  WORD_W  loaded word, valid when dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- abort  out  1  one-cycle pulse: access dropped after ERR_RETRY_MAX errors

Behaviour:
- Reset (async, nRST=0): state=IDLE; prio=DATA; retry count=0; latched op/addr/store cleared. Outputs ihit, dhit, ramREN, ramWEN and abort are 0. Buses ramaddr, ramstore, iload and dload are 0. Reset mid-access abandons the access with no hit.
- FSM states: IDLE, DACC, IACC.
- IDLE grant:
  - Eligible requesters: data when dREN|dWEN; instruction when iREN and !halt.
  - Both eligible: grant goes to prio. prio flips after every grant so neither side starves.
  - Single eligible: grant goes to it.
  - On grant, latch the op (read/write), address and store data; go to DACC or IACC. No RAM strobe is driven in IDLE.
- DACC/IACC RAM drive: drive ramREN/ramWEN, ramaddr and ramstore from the latched registers. Strobes are held steady every cycle until exit.
- ramstate handling in DACC/IACC:
  - FREE or BUSY: hold.
  - ACCESS: combinationally assert dhit (DACC) or ihit (IACC) in the same cycle. dload/iload = ramload passthrough; for writes dload is 0. Next state IDLE; retry count cleared.
  - ERROR: increment the retry count and keep strobes asserted so the access is re-issued. When the count reaches ERR_RETRY_MAX: pulse abort, no hit, return to IDLE.
- Latency: a minimum access takes 2 cycles (grant cycle plus ACCESS cycle). The requester drops or changes its request the cycle after its hit, so IDLE never double-grants.
- halt rising during IACC: the current fetch completes normally; no further instruction grants. Data grants continue.
- ihit and dhit are never both 1. iload is 0 when ihit=0; dload is 0 when dhit=0.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined:
  - Adds outputs icount[31:0], dcount[31:0] and errcount[31:0], reset to 0.
  - icount increments on each ihit, dcount on each dhit, errcount on each ERROR cycle in DACC/IACC.
  - Counters saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then iREN=1, iaddr=0x0, ramstate FREE→ACCESS on the 2nd cycle, ramload=0x3C010010 -> ihit one cycle; iload=0x3C010010; ramREN=1, ramaddr=0x0 while in IACC.
- iREN and dREN both held, prio=DATA after reset, 1-cycle ACCESS each -> grant order D, I, D, I; ihit and dhit never simultaneous.
- dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 and ramstore=0xDEADBEEF held for all 4 cycles; dhit on the ACCESS cycle; dload=0.
- ramstate=ERROR for 4 consecutive cycles with ERR_RETRY_MAX=4 -> abort pulses once; no hit; FSM returns to IDLE; next request is served normally.
- halt=1 while iREN=1 and IACC is in progress -> current ihit completes; no further ramREN for instructions; a subsequent dREN is still served.
- nRST pulsed low mid-DACC (ramstate BUSY) -> all outputs 0 immediately; no dhit; with MEM_ARBITER_PERF_EN defined, icount/dcount/errcount read 0.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Arbitrates instruction-fetch and data-access requests onto one RAM port, tracks wait/error states.
// Optional performance counters are enabled by defining MEM_ARBITER_PERF_EN.
module mem_request_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int WORD_W        = 32,
  parameter int ERR_RETRY_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic              halt,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              abort
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       errcount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_e;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic PRIO_DATA = 1'b0;

  localparam int RW = (ERR_RETRY_MAX < 1) ? 1 : $clog2(ERR_RETRY_MAX + 1);
  // Index of the error that exhausts the budget; a budget below one behaves as one.
  localparam logic [RW-1:0] RETRY_LAST = (ERR_RETRY_MAX < 1) ? '0 : RW'(ERR_RETRY_MAX - 1);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;

  logic d_elig;
  logic i_elig;
  logic err_cycle;

  assign d_elig = dREN | dWEN;
  assign i_elig = iREN & ~halt;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    retry_d   = retry_q;
    write_d   = write_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    abort     = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    err_cycle = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins when it is alone or when it holds priority; prio toggles on every grant.
        if (d_elig && (!i_elig || prio_q == PRIO_DATA)) begin
          state_d = DACC;
          write_d = dWEN;
          addr_d  = daddr;
          store_d = dstore;
          prio_d  = ~prio_q;
          retry_d = '0;
        end else if (i_elig) begin
          state_d = IACC;
          write_d = 1'b0;
          addr_d  = iaddr;
          store_d = '0;
          prio_d  = ~prio_q;
          retry_d = '0;
        end
      end

      DACC, IACC: begin
        ramREN   = ~write_q;
        ramWEN   = write_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (ramstate == RS_ACCESS) begin
          if (state_q == DACC) begin
            dhit  = 1'b1;
            dload = write_q ? '0 : ramload;
          end else begin
            ihit  = 1'b1;
            iload = ramload;
          end
          state_d = IDLE;
          retry_d = '0;
        end else if (ramstate == RS_ERROR) begin
          err_cycle = 1'b1;
          if (retry_q >= RETRY_LAST) begin
            abort   = 1'b1;
            state_d = IDLE;
            retry_d = '0;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      prio_q  <= PRIO_DATA;
      retry_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      retry_q <= retry_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] icount_q, dcount_q, errcount_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q   <= '0;
      dcount_q   <= '0;
      errcount_q <= '0;
    end else begin
      if (ihit && icount_q != '1) icount_q <= icount_q + 32'd1;
      if (dhit && dcount_q != '1) dcount_q <= dcount_q + 32'd1;
      if (err_cycle && errcount_q != '1) errcount_q <= errcount_q + 32'd1;
    end
  end

  assign icount   = icount_q;
  assign dcount   = dcount_q;
  assign errcount = errcount_q;
`else
  logic unused_err_cycle;
  assign unused_err_cycle = err_cycle;
`endif

endmodule
